// File: rtl/video_sync_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_sync_pkg
//  Description : Shared types and constants for the video sync timing block.
//  Revision    : 1.0 - initial release
// ============================================================================
package video_sync_pkg;

  // Default width of every timing field, counter and position output.
  localparam int CNT_W_DEFAULT = 16;

  // Extra bits carried by the summed frame totals so that a sum of four
  // full-width fields can be range-checked without overflow.
  localparam int TOT_EXTRA_W = 2;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_RUN       = 2'd2
  } state_e;

  // Width of the line/frame total arithmetic for a given counter width.
  function automatic int tot_w(input int cnt_w);
    return cnt_w + TOT_EXTRA_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/video_sync_hv_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : video_sync_hv_cnt
//  Description : Horizontal/vertical position counter pair. hcnt wraps at the
//                last pixel of a line and advances vcnt; o_last flags the
//                final pixel of the frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_sync_hv_cnt
  import video_sync_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_run,
  input  logic [CNT_W-1:0] i_hlast,
  input  logic [CNT_W-1:0] i_vlast,
  output logic [CNT_W-1:0] o_hcnt,
  output logic [CNT_W-1:0] o_vcnt,
  output logic             o_last
);

  logic [CNT_W-1:0] hcnt_q;
  logic [CNT_W-1:0] vcnt_q;
  logic             w_hwrap;
  logic             w_vwrap;

  assign w_hwrap = (hcnt_q == i_hlast);
  assign w_vwrap = (vcnt_q == i_vlast);

  // Pixel/line counters: clear on frame start, advance only while running.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else if (i_clr) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else if (i_run) begin
      if (w_hwrap) begin
        hcnt_q <= '0;
        vcnt_q <= w_vwrap ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_q <= hcnt_q + 1'b1;
      end
    end
  end

  assign o_hcnt = hcnt_q;
  assign o_vcnt = vcnt_q;
  assign o_last = w_hwrap & w_vwrap;

endmodule
`default_nettype wire

// File: rtl/video_sync_timing_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : video_sync_timing_ctrl
//  Description : Frame-locked video sync generator. Waits for an input frame
//                strobe, latches the timing configuration, then produces one
//                frame of hsync/vsync/de before waiting for the next strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_sync_timing_ctrl
  import video_sync_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_vsync_sync,
  input  logic             i_mirror_mode_cap,
  input  logic             i_blur_mode_cap,
  input  logic [CNT_W-1:0] i_hsw,
  input  logic [CNT_W-1:0] i_hbp,
  input  logic [CNT_W-1:0] i_hact,
  input  logic [CNT_W-1:0] i_hfp,
  input  logic [CNT_W-1:0] i_vsw,
  input  logic [CNT_W-1:0] i_vbp,
  input  logic [CNT_W-1:0] i_vact,
  input  logic [CNT_W-1:0] i_vfp,
  output logic             o_vsync,
  output logic             o_hsync,
  output logic             o_de,
  output logic [CNT_W-1:0] o_hcnt,
  output logic [CNT_W-1:0] o_vcnt,
  output logic             o_busy,
  output logic             o_frame_done,
  output logic             o_overrun,
  output logic             o_cfg_err
);

  localparam int             TW        = tot_w(CNT_W);
  localparam logic [TW-1:0]  MAX_TOTAL = TW'(1) << CNT_W;

  state_e           state_q;
  state_e           state_d;
  logic             vs_d_q;
  logic             cfg_err_q;
  logic             overrun_q;

  // Latched per-frame timing, decoded into the boundaries the outputs need.
  logic [CNT_W-1:0] hsw_q;
  logic [CNT_W-1:0] vsw_q;
  logic [TW-1:0]    hde_lo_q;
  logic [TW-1:0]    hde_hi_q;
  logic [TW-1:0]    vde_lo_q;
  logic [TW-1:0]    vde_hi_q;
  logic [CNT_W-1:0] hlast_q;
  logic [CNT_W-1:0] vlast_q;

  logic             w_en;
  logic             w_vs_rise;
  logic             w_run;
  logic             w_start;
  logic             w_reject;
  logic             w_cfg_bad;
  logic [TW-1:0]    w_hde_lo;
  logic [TW-1:0]    w_hde_hi;
  logic [TW-1:0]    w_htotal;
  logic [TW-1:0]    w_vde_lo;
  logic [TW-1:0]    w_vde_hi;
  logic [TW-1:0]    w_vtotal;
  logic [CNT_W-1:0] w_hcnt;
  logic [CNT_W-1:0] w_vcnt;
  logic             w_last;
  logic             w_h_in_de;
  logic             w_v_in_de;

  assign w_en      = i_mirror_mode_cap | i_blur_mode_cap;
  assign w_vs_rise = i_vsync_sync & ~vs_d_q;
  assign w_run     = (state_q == ST_RUN);

  // Running sums of the live timing inputs; only captured on an accepted start.
  assign w_hde_lo  = TW'(i_hsw) + TW'(i_hbp);
  assign w_hde_hi  = w_hde_lo + TW'(i_hact);
  assign w_htotal  = w_hde_hi + TW'(i_hfp);
  assign w_vde_lo  = TW'(i_vsw) + TW'(i_vbp);
  assign w_vde_hi  = w_vde_lo + TW'(i_vact);
  assign w_vtotal  = w_vde_hi + TW'(i_vfp);

  // A frame needs visible sync and active regions and must fit the counters.
  assign w_cfg_bad = (i_hsw == '0) | (i_hact == '0) |
                     (i_vsw == '0) | (i_vact == '0) |
                     (w_htotal > MAX_TOTAL) | (w_vtotal > MAX_TOTAL);

  // Next-state logic; losing enable overrides everything, including a start.
  always_comb begin
    state_d  = state_q;
    w_start  = 1'b0;
    w_reject = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_en) state_d = ST_WAIT_SYNC;
      end
      ST_WAIT_SYNC: begin
        if (w_vs_rise) begin
          if (w_cfg_bad) begin
            w_reject = 1'b1;
          end else begin
            w_start = 1'b1;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (w_last) state_d = ST_WAIT_SYNC;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!w_en) begin
      state_d  = ST_IDLE;
      w_start  = 1'b0;
      w_reject = 1'b0;
    end
  end

  // State register plus input-strobe history for edge detection.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state_q <= ST_IDLE;
      vs_d_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vs_d_q  <= i_vsync_sync;
    end
  end

  // Status flags: sticky config error, one-cycle overrun on a strobe mid-frame.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      cfg_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= w_run & w_vs_rise;
      if (w_start) begin
        cfg_err_q <= 1'b0;
      end else if (w_reject) begin
        cfg_err_q <= 1'b1;
      end
    end
  end

  // Timing snapshot taken at frame start so mid-frame input changes are inert.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      hsw_q    <= '0;
      vsw_q    <= '0;
      hde_lo_q <= '0;
      hde_hi_q <= '0;
      vde_lo_q <= '0;
      vde_hi_q <= '0;
      hlast_q  <= '0;
      vlast_q  <= '0;
    end else if (w_start) begin
      hsw_q    <= i_hsw;
      vsw_q    <= i_vsw;
      hde_lo_q <= w_hde_lo;
      hde_hi_q <= w_hde_hi;
      vde_lo_q <= w_vde_lo;
      vde_hi_q <= w_vde_hi;
      hlast_q  <= CNT_W'(w_htotal - TW'(1));
      vlast_q  <= CNT_W'(w_vtotal - TW'(1));
    end
  end

  video_sync_hv_cnt #(
    .CNT_W (CNT_W)
  ) u_hv_cnt (
    .i_clk   (i_CLK),
    .i_rst_n (i_RST),
    .i_clr   (w_start),
    .i_run   (w_run),
    .i_hlast (hlast_q),
    .i_vlast (vlast_q),
    .o_hcnt  (w_hcnt),
    .o_vcnt  (w_vcnt),
    .o_last  (w_last)
  );

  assign w_h_in_de = (TW'(w_hcnt) >= hde_lo_q) & (TW'(w_hcnt) < hde_hi_q);
  assign w_v_in_de = (TW'(w_vcnt) >= vde_lo_q) & (TW'(w_vcnt) < vde_hi_q);

  assign o_hsync      = w_run & (w_hcnt < hsw_q);
  assign o_vsync      = w_run & (w_vcnt < vsw_q);
  assign o_de         = w_run & w_h_in_de & w_v_in_de;
  assign o_hcnt       = w_run ? w_hcnt : '0;
  assign o_vcnt       = w_run ? w_vcnt : '0;
  assign o_busy       = w_run;
  assign o_frame_done = w_run & w_last;
  assign o_overrun    = overrun_q;
  assign o_cfg_err    = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_video_sync_timing_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_sync_timing_ctrl
//  Description : Self-checking bench for video_sync_timing_ctrl. Expected
//                outputs come from a frame model: pixel k of a frame sits at
//                h = k mod htotal, v = k div htotal.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_sync_timing_ctrl;

  localparam int CNT_W = 16;

  logic             i_CLK = 1'b0;
  logic             i_RST;
  logic             i_vsync_sync;
  logic             i_mirror_mode_cap;
  logic             i_blur_mode_cap;
  logic [CNT_W-1:0] i_hsw, i_hbp, i_hact, i_hfp;
  logic [CNT_W-1:0] i_vsw, i_vbp, i_vact, i_vfp;
  logic             o_vsync, o_hsync, o_de;
  logic [CNT_W-1:0] o_hcnt, o_vcnt;
  logic             o_busy, o_frame_done, o_overrun, o_cfg_err;

  int checks = 0;
  int errors = 0;

  // Configuration currently driven, and the copy the model froze at start.
  int cfg_h[4];
  int cfg_v[4];
  int m_h[4];
  int m_v[4];

  // Per-frame tallies filled by run_frame.
  int cnt_vs, cnt_hs, cnt_de, done_at;

  video_sync_timing_ctrl #(.CNT_W(CNT_W)) dut (
    .i_CLK             (i_CLK),
    .i_RST             (i_RST),
    .i_vsync_sync      (i_vsync_sync),
    .i_mirror_mode_cap (i_mirror_mode_cap),
    .i_blur_mode_cap   (i_blur_mode_cap),
    .i_hsw             (i_hsw),
    .i_hbp             (i_hbp),
    .i_hact            (i_hact),
    .i_hfp             (i_hfp),
    .i_vsw             (i_vsw),
    .i_vbp             (i_vbp),
    .i_vact            (i_vact),
    .i_vfp             (i_vfp),
    .o_vsync           (o_vsync),
    .o_hsync           (o_hsync),
    .o_de              (o_de),
    .o_hcnt            (o_hcnt),
    .o_vcnt            (o_vcnt),
    .o_busy            (o_busy),
    .o_frame_done      (o_frame_done),
    .o_overrun         (o_overrun),
    .o_cfg_err         (o_cfg_err)
  );

  always #5 i_CLK = ~i_CLK;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_CLK);
    #1;
  endtask

  task automatic set_en(input int mode);
    i_mirror_mode_cap = mode[0];
    i_blur_mode_cap   = mode[1];
  endtask

  task automatic apply_cfg(input int h0, input int h1, input int h2, input int h3,
                           input int v0, input int v1, input int v2, input int v3);
    cfg_h = '{h0, h1, h2, h3};
    cfg_v = '{v0, v1, v2, v3};
    i_hsw = CNT_W'(h0); i_hbp = CNT_W'(h1); i_hact = CNT_W'(h2); i_hfp = CNT_W'(h3);
    i_vsw = CNT_W'(v0); i_vbp = CNT_W'(v1); i_vact = CNT_W'(v2); i_vfp = CNT_W'(v3);
  endtask

  // All generated outputs quiet and not busy.
  task automatic chk_quiet(input string tag);
    chk({tag, "_hsync"}, o_hsync, 1'b0);
    chk({tag, "_vsync"}, o_vsync, 1'b0);
    chk({tag, "_de"},    o_de,    1'b0);
    chk({tag, "_busy"},  o_busy,  1'b0);
    chk({tag, "_done"},  o_frame_done, 1'b0);
    chk({tag, "_hcnt"},  o_hcnt,  '0);
    chk({tag, "_vcnt"},  o_vcnt,  '0);
  endtask

  // Two settle cycles, then one strobe; the model freezes the driven config.
  task automatic start_frame();
    i_vsync_sync = 1'b0;
    tick();
    tick();
    i_vsync_sync = 1'b1;
    tick();
    i_vsync_sync = 1'b0;
    m_h = cfg_h;
    m_v = cfg_v;
  endtask

  // Walk one frame cycle by cycle against the model. ov_k: cycle on which a
  // strobe is raised (-1 none). drop_k: cycle after which enable drops (-1
  // none). scramble: rewrite the timing inputs early in the frame.
  task automatic run_frame(input int ov_k, input int drop_k, input bit scramble);
    int ht, vt, n, h, v, hde0, vde0;
    bit ov_pend;
    ht = m_h[0] + m_h[1] + m_h[2] + m_h[3];
    vt = m_v[0] + m_v[1] + m_v[2] + m_v[3];
    n  = ht * vt;
    hde0 = m_h[0] + m_h[1];
    vde0 = m_v[0] + m_v[1];
    ov_pend = 1'b0;
    cnt_vs = 0; cnt_hs = 0; cnt_de = 0; done_at = -1;
    for (int k = 0; k < n; k++) begin
      h = k % ht;
      v = k / ht;
      chk("hcnt",  o_hcnt, h);
      chk("vcnt",  o_vcnt, v);
      chk("hsync", o_hsync, h < m_h[0]);
      chk("vsync", o_vsync, v < m_v[0]);
      chk("de",    o_de, (h >= hde0) && (h < hde0 + m_h[2]) && (v >= vde0) && (v < vde0 + m_v[2]));
      chk("done",  o_frame_done, k == n - 1);
      chk("busy",  o_busy, 1'b1);
      chk("overrun", o_overrun, ov_pend);
      if (o_vsync) cnt_vs++;
      if (o_hsync) cnt_hs++;
      if (o_de) cnt_de++;
      if (o_frame_done) done_at = k + 1;
      ov_pend = 1'b0;
      i_vsync_sync = 1'b0;
      if (k == ov_k) begin
        i_vsync_sync = 1'b1;
        ov_pend = 1'b1;
      end
      if (scramble && k == 1)
        apply_cfg($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      if (k == drop_k) begin
        set_en(0);
        tick();
        chk_quiet("drop_next");
        for (int j = 0; j < 5; j++) begin
          tick();
          chk("drop_done", o_frame_done, 1'b0);
          chk("drop_busy", o_busy, 1'b0);
        end
        return;
      end
      tick();
    end
    i_vsync_sync = 1'b0;
    chk_quiet("post");
    chk("post_overrun", o_overrun, ov_pend);
  endtask

  // Present a configuration and one strobe; it must be refused.
  task automatic expect_reject(input string tag);
    start_frame();
    chk({tag, "_cfg_err"}, o_cfg_err, 1'b1);
    chk_quiet(tag);
    for (int j = 0; j < 3; j++) begin
      tick();
      chk({tag, "_idle_busy"}, o_busy, 1'b0);
    end
  endtask

  initial begin
    i_RST = 1'b0;
    i_vsync_sync = 1'b0;
    set_en(0);
    apply_cfg(2, 2, 8, 2, 1, 1, 4, 1);

    // Reset state.
    tick();
    tick();
    chk_quiet("reset");
    chk("reset_cfg_err", o_cfg_err, 1'b0);
    chk("reset_overrun", o_overrun, 1'b0);
    i_RST = 1'b1;
    tick();

    // Disabled: strobes are ignored.
    for (int j = 0; j < 3; j++) begin
      i_vsync_sync = 1'b1;
      tick();
      chk_quiet("dis_hi");
      i_vsync_sync = 1'b0;
      tick();
      chk_quiet("dis_lo");
    end

    // Enabled but no strobe yet: still waiting.
    set_en(1);
    for (int j = 0; j < 4; j++) begin
      tick();
      chk_quiet("wait");
    end

    // Reference frame 14 x 7.
    start_frame();
    run_frame(-1, -1, 1'b0);
    chk("ref_vsync_cycles", cnt_vs, 14);
    chk("ref_hsync_cycles", cnt_hs, 14);
    chk("ref_de_cycles",    cnt_de, 32);
    chk("ref_done_cycle",   done_at, 98);
    for (int j = 0; j < 4; j++) begin
      tick();
      chk_quiet("locked");
    end

    // Invalid configuration, then recovery.
    set_en(2);
    apply_cfg(2, 2, 0, 2, 1, 1, 4, 1);
    expect_reject("hact0");
    apply_cfg(2, 2, 8, 2, 1, 1, 4, 1);
    start_frame();
    chk("recover_cfg_err", o_cfg_err, 1'b0);
    run_frame(-1, -1, 1'b0);

    // Strobe mid-frame at vcnt=3.
    set_en(3);
    start_frame();
    run_frame(3 * 14 + 5, -1, 1'b0);
    chk("ovr_done_cycle", done_at, 98);

    // Strobe on the last cycle: no restart, next frame needs a fresh strobe.
    start_frame();
    run_frame(97, -1, 1'b0);
    i_vsync_sync = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk_quiet("last_ovr_hold");
    end
    i_vsync_sync = 1'b0;
    start_frame();
    run_frame(-1, -1, 1'b0);

    // Enable drops at vcnt=2.
    start_frame();
    run_frame(2 * 14 + 3, -1 + 2 * 14 + 4, 1'b0);
    set_en(1);

    // Reset mid-frame.
    start_frame();
    for (int j = 0; j < 20; j++) tick();
    chk("pre_rst_busy", o_busy, 1'b1);
    #2;
    i_RST = 1'b0;
    #1;
    chk_quiet("async_rst");
    chk("async_rst_overrun", o_overrun, 1'b0);
    tick();
    i_RST = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk_quiet("post_rst");
    end
    start_frame();
    run_frame(-1, -1, 1'b0);

    // Boundary: htotal exactly 2^16 is accepted.
    apply_cfg(32768, 0, 32768, 0, 1, 0, 1, 0);
    start_frame();
    chk("max_busy", o_busy, 1'b1);
    chk("max_cfg_err", o_cfg_err, 1'b0);
    tick(); tick(); tick();
    chk("max_hcnt", o_hcnt, 3);
    chk("max_hsync", o_hsync, 1'b1);
    set_en(0);
    tick();
    chk_quiet("max_drop");
    set_en(2);

    // Boundary: totals one past 2^16 are refused.
    apply_cfg(32768, 1, 32768, 0, 1, 0, 1, 0);
    expect_reject("htot_ovf");
    apply_cfg(1, 0, 1, 0, 1, 0, 1, 0);
    start_frame();
    chk("tiny_cfg_err", o_cfg_err, 1'b0);
    run_frame(-1, -1, 1'b0);
    apply_cfg(2, 0, 2, 0, 32768, 1, 32768, 0);
    expect_reject("vtot_ovf");
    apply_cfg(0, 1, 2, 1, 1, 1, 1, 1);
    expect_reject("hsw0");

    // Randomized frames with inputs rewritten mid-frame.
    for (int r = 0; r < 8; r++) begin
      int ovk;
      set_en($urandom_range(1, 3));
      apply_cfg($urandom_range(1, 3), $urandom_range(0, 3), $urandom_range(1, 6), $urandom_range(0, 3),
                $urandom_range(1, 2), $urandom_range(0, 2), $urandom_range(1, 3), $urandom_range(0, 2));
      start_frame();
      chk("rnd_cfg_err", o_cfg_err, 1'b0);
      ovk = ($urandom_range(0, 1) == 1) ?
            $urandom_range(0, (m_h[0] + m_h[1] + m_h[2] + m_h[3]) * (m_v[0] + m_v[1] + m_v[2] + m_v[3]) - 1) : -1;
      run_frame(ovk, -1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
